// File: rtl/ysyx_23060096_pkg.sv
// ysyx_23060096_pkg: MemOP encodings, access sizes and LSU FSM states.
// Shared by the LSU and its align sub-module; no ports.
package ysyx_23060096_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } sz_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } lsu_st_e;

    // Reserved codes (011, 110, 111) fall through to word.
    function automatic sz_e op_size(input logic [2:0] op);
        case (op)
            OP_B, OP_BU: op_size = SZ_B;
            OP_H, OP_HU: op_size = SZ_H;
            default:     op_size = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060096_lsu_align.sv
// ysyx_23060096_lsu_align: store mask/replication and load extension.
// in: wr, op, off, wdata, mem_rdata; out: wmask, mem_wdata, ld_data.
// Macro YSYX_23060096_LSU_MISALIGN_EN: keep the raw offset; otherwise
// the offset is forced to {off[1],0} for halfwords and 0 for words.
module ysyx_23060096_lsu_align (
    input  logic        wr,
    input  logic [2:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  wmask,
    output logic [31:0] mem_wdata,
    output logic [31:0] ld_data
);
    import ysyx_23060096_pkg::*;

    sz_e         sz;
    logic        is_b;
    logic        is_h;
    logic        sext;
    logic [1:0]  eoff;
    logic [31:0] sh;

    assign sz   = op_size(op);
    assign is_b = (sz == SZ_B);
    assign is_h = (sz == SZ_H);
    assign sext = ~op[2];

`ifdef YSYX_23060096_LSU_MISALIGN_EN
    assign eoff = off;
`else
    always_comb begin
        eoff = off;
        if (is_h) begin
            eoff = {off[1], 1'b0};
        end else if (!is_b) begin
            eoff = 2'b00;
        end
    end
`endif

    assign sh = mem_rdata >> {eoff, 3'b000};

    always_comb begin
        wmask     = 4'b1111;
        mem_wdata = wdata;
        ld_data   = sh;
        unique case (1'b1)
            is_b: begin
                wmask     = 4'b0001 << eoff;
                mem_wdata = {4{wdata[7:0]}};
                ld_data   = {{24{sh[7] & sext}}, sh[7:0]};
            end
            is_h: begin
                wmask     = 4'b0011 << eoff;
                mem_wdata = {2{wdata[15:0]}};
                ld_data   = {{16{sh[15] & sext}}, sh[15:0]};
            end
            default: begin
                wmask     = 4'b1111;
                mem_wdata = wdata;
                ld_data   = sh;
            end
        endcase
        if (!wr) begin
            wmask = 4'b0000;
        end
    end

endmodule

// File: rtl/ysyx_23060096_lsu.sv
// ysyx_23060096_lsu: single-outstanding load/store unit, IDLE/REQ/RESP/DONE.
// Core side: req_valid/req_ready, MemWr, MemOP, addr, wdata -> resp_valid,
// rdata, err. Memory side: mem_valid/mem_ready, mem_wen, mem_addr,
// mem_wdata, mem_wmask; mem_rvalid/mem_rdata back.
// Macro YSYX_23060096_LSU_MISALIGN_EN: misaligned h/w skip memory, err=1.
module ysyx_23060096_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              MemWr,
    input  logic [2:0]        MemOP,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              resp_valid,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);
    import ysyx_23060096_pkg::*;

    lsu_st_e           st_q;
    lsu_st_e           st_d;
    logic              wr_q;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [31:0]       ld_data;
    logic              acc;
    logic              mis;

`ifdef YSYX_23060096_LSU_MISALIGN_EN
    sz_e sz_in;
    assign sz_in = op_size(MemOP);
    assign mis   = ((sz_in == SZ_H) && addr[0])
                 || ((sz_in == SZ_W) && (addr[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    assign acc = req_valid && (st_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d       = st_q;
        req_ready  = 1'b0;
        mem_valid  = 1'b0;
        resp_valid = 1'b0;
        unique case (st_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    st_d = mis ? DONE : REQ;
                end
            end
            REQ: begin
                mem_valid = 1'b1;
                if (mem_ready) begin
                    st_d = RESP;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    st_d = DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                st_d       = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            op_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            if (acc) begin
                wr_q    <= MemWr;
                op_q    <= MemOP;
                addr_q  <= addr;
                wdata_q <= wdata;
                err_q   <= mis;
                if (mis) begin
                    rdata_q <= 32'h0;
                end
            end
            if ((st_q == RESP) && mem_rvalid) begin
                rdata_q <= wr_q ? 32'h0 : ld_data;
            end
        end
    end

    ysyx_23060096_lsu_align u_align (
        .wr        (wr_q),
        .op        (op_q),
        .off       (addr_q[1:0]),
        .wdata     (wdata_q),
        .mem_rdata (mem_rdata),
        .wmask     (mem_wmask),
        .mem_wdata (mem_wdata),
        .ld_data   (ld_data)
    );

    assign mem_wen  = wr_q;
    assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign rdata    = rdata_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ysyx_23060096_lsu.sv
// tb_ysyx_23060096_lsu: scoreboard bench for the LSU.
// Expected responses queued at request time, popped on resp_valid.
module tb_ysyx_23060096_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        MemWr = 1'b0;
    logic [2:0]  MemOP = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        err;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    typedef struct {
        logic [31:0] rd;
        logic        er;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   n_tot = 0;
    int   n_bad = 0;
    int   last_resp = -100;
    int   last_gap = 0;
    exp_t mon_e;
    int   mon_a;

    ysyx_23060096_lsu #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .MemWr      (MemWr),
        .MemOP      (MemOP),
        .addr       (addr),
        .wdata      (wdata),
        .resp_valid (resp_valid),
        .rdata      (rdata),
        .err        (err),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && req_valid && req_ready) begin
            acc_q.push_back(cyc);
            last_gap = cyc - last_resp;
        end
        if (resp_valid) begin
            chk("orphan_resp",
                32'(sb_q.size() != 0 && acc_q.size() != 0), 32'd1);
            if (sb_q.size() != 0 && acc_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                mon_a = acc_q.pop_front();
                chk("rdata", rdata, mon_e.rd);
                chk("err", 32'(err), 32'(mon_e.er));
                chk("latency", 32'(cyc - mon_a), 32'(mon_e.lat));
            end
            last_resp = cyc;
        end
    end

    function automatic void model(
        input  logic        wr,
        input  logic [2:0]  op,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        input  logic [31:0] mrd,
        output logic        mis,
        output logic [3:0]  m,
        output logic [31:0] mw,
        output logic [31:0] rd
    );
        int          sz;
        logic [1:0]  o;
        logic [31:0] v;
        if (op == 3'b000 || op == 3'b100) sz = 1;
        else if (op == 3'b001 || op == 3'b101) sz = 2;
        else sz = 4;
        o = a[1:0];
`ifdef YSYX_23060096_LSU_MISALIGN_EN
        mis = (sz == 2 && o[0]) || (sz == 4 && o != 2'b00);
`else
        mis = 1'b0;
        if (sz == 2) o[0] = 1'b0;
        if (sz == 4) o = 2'b00;
`endif
        v = mrd >> (8 * o);
        case (sz)
            1: begin
                m  = 4'b0001 << o;
                mw = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
                rd = op[2] ? {24'h0, v[7:0]} : 32'($signed(v[7:0]));
            end
            2: begin
                m  = 4'b0011 << o;
                mw = {wd[15:0], wd[15:0]};
                rd = op[2] ? {16'h0, v[15:0]} : 32'($signed(v[15:0]));
            end
            default: begin
                m  = 4'b1111;
                mw = wd;
                rd = v;
            end
        endcase
        if (!wr) m = 4'b0000;
        if (wr || mis) rd = 32'h0;
    endfunction

    task automatic mem_serve(input int wn, input logic [31:0] mrd,
                             input logic [31:0] ea, input logic [3:0] em,
                             input logic [31:0] ew, input logic ewen);
        int t = 0;
        mem_ready = 1'b0;
        while (!mem_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("mem_valid_to", 32'(t < 50), 32'd1);
        for (int k = 0; k < wn; k++) begin
            chk("maddr_hold", mem_addr, ea);
            chk("mvalid_hold", 32'(mem_valid), 32'd1);
            @(posedge clk); #1;
        end
        chk("mem_valid", 32'(mem_valid), 32'd1);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wmask", 32'(mem_wmask), 32'(em));
        chk("mem_wen", 32'(mem_wen), 32'(ewen));
        if (ewen) chk("mem_wdata", mem_wdata, ew);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = mrd;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (sb_q.size() != 0 && t < 30) begin
            @(posedge clk); #1;
            t++;
        end
        chk("resp_to", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic do_op(input logic wr, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] mrd, input int wn);
        logic        mis;
        logic [3:0]  m;
        logic [31:0] mw;
        logic [31:0] rd;
        int          t = 0;
        model(wr, op, a, wd, mrd, mis, m, mw, rd);
        sb_q.push_back('{rd: rd, er: mis, lat: (mis ? 1 : 3 + wn)});
        MemWr     = wr;
        MemOP     = op;
        addr      = a;
        wdata     = wd;
        req_valid = 1'b1;
        while (!req_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("accept_to", 32'(t < 50), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (mis) chk("mis_no_mem", 32'(mem_valid), 32'd0);
        else mem_serve(wn, mrd, {a[31:2], 2'b00}, m, mw, wr);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ops[8];
        ops = '{3'b000, 3'b001, 3'b010, 3'b100,
                3'b101, 3'b011, 3'b110, 3'b111};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        do_op(1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 32'h0, 0);
        do_op(1'b0, 3'b000, 32'h8000_0002, 32'h0, 32'h00F0_0000, 0);
        do_op(1'b0, 3'b100, 32'h8000_0002, 32'h0, 32'h00F0_0000, 0);
        do_op(1'b0, 3'b101, 32'h8000_0006, 32'h0, 32'h8001_1234, 5);
        do_op(1'b1, 3'b001, 32'h8000_0002, 32'h0000_1234, 32'h0, 1);
        do_op(1'b1, 3'b010, 32'h8000_0008, 32'hDEAD_BEEF, 32'h0, 0);
        do_op(1'b0, 3'b001, 32'h8000_0010, 32'h0, 32'h0000_8765, 2);
        do_op(1'b0, 3'b111, 32'h8000_0004, 32'h0, 32'hCAFE_BABE, 0);
        do_op(1'b1, 3'b011, 32'h8000_000C, 32'h1357_9BDF, 32'h0, 0);
        do_op(1'b0, 3'b010, 32'h0000_0002, 32'h0, 32'h1122_3344, 0);
        do_op(1'b0, 3'b001, 32'h8000_0001, 32'h0, 32'h0000_F0AA, 0);

        // back-to-back loads with req_valid held high
        sb_q.push_back('{rd: 32'h1111_1111, er: 1'b0, lat: 3});
        sb_q.push_back('{rd: 32'h2222_2222, er: 1'b0, lat: 3});
        MemWr     = 1'b0;
        MemOP     = 3'b010;
        addr      = 32'h8000_0100;
        wdata     = 32'h0;
        req_valid = 1'b1;
        mem_serve(0, 32'h1111_1111, 32'h8000_0100, 4'b0000, 32'h0, 1'b0);
        mem_serve(0, 32'h2222_2222, 32'h8000_0100, 4'b0000, 32'h0, 1'b0);
        req_valid = 1'b0;
        wait_idle();
        chk("b2b_gap", 32'(last_gap), 32'd1);

        // reset while waiting in RESP
        MemWr     = 1'b1;
        MemOP     = 3'b010;
        addr      = 32'h8000_0010;
        wdata     = 32'hA5A5_A5A5;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        chk("in_resp_mvalid", 32'(mem_valid), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_mvalid", 32'(mem_valid), 32'd0);
        chk("mid_rst_resp", 32'(resp_valid), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_rdata", rdata, 32'h0);
        chk("mid_rst_maddr", mem_addr, 32'h0);
        chk("mid_rst_wmask", 32'(mem_wmask), 32'd0);
        chk("mid_rst_wen", 32'(mem_wen), 32'd0);
        sb_q.delete();
        acc_q.delete();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rel_req_ready", 32'(req_ready), 32'd1);
        repeat (4) begin
            @(posedge clk); #1;
            chk("no_resp_after_rst", 32'(resp_valid), 32'd0);
        end
        mem_rvalid = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_op(1'($urandom_range(0, 1)), ops[$urandom_range(0, 7)],
                  32'h8000_1000 + 32'($urandom_range(0, 15)),
                  $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
